// File: rtl/hilo_bank.sv
// hilo_bank: HI/LO register pair with per-half forwarding, MDU pending tracking and EX read stall
module hilo_bank #(
  parameter int XLEN     = 32,
  parameter int NFWD     = 2,
  parameter int MAX_PEND = 3,
  parameter int PW       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*NFWD-1:0]      fwd_we,
  input  logic [2*XLEN*NFWD-1:0] fwd_data,
  input  logic [1:0]             wb_we,
  input  logic [2*XLEN-1:0]      wb_data,
  input  logic                   md_issue,
  input  logic                   md_done,
  input  logic [1:0]             md_we,
  input  logic [2*XLEN-1:0]      md_data,
  input  logic                   flush,
  input  logic                   rd_req,
  output logic [2*XLEN-1:0]      rd_data,
  output logic                   rd_stall,
  output logic [PW-1:0]          pend_cnt,
  output logic                   pend_err
);
  logic [XLEN-1:0] hi_q, lo_q, hi_d, lo_d, rd_hi, rd_lo;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            cnt_zero, cnt_full, done_acc, issue_acc;
  assign cnt_zero  = cnt_q == '0;
  assign cnt_full  = cnt_q == PW'(MAX_PEND);
  assign done_acc  = md_done && !cnt_zero && !flush;
  assign issue_acc = md_issue && !cnt_full && !flush;
  // Next register state per half: WB overrides an accepted MDU result, otherwise hold
  always_comb begin
    hi_d  = wb_we[1] ? wb_data[2*XLEN-1:XLEN] : (done_acc && md_we[1]) ? md_data[2*XLEN-1:XLEN] : hi_q;
    lo_d  = wb_we[0] ? wb_data[XLEN-1:0] : (done_acc && md_we[0]) ? md_data[XLEN-1:0] : lo_q;
    cnt_d = flush ? '0 : cnt_q + PW'(issue_acc) - PW'(done_acc);
    err_d = err_q || (!flush && ((md_issue && cnt_full) || (md_done && cnt_zero)));
  end
  // Read mux: youngest enabled forwarding stage wins, else the WB/MDU/register chain
  always_comb begin
    rd_hi = hi_d;
    rd_lo = lo_d;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_we[2*i+1]) rd_hi = fwd_data[2*XLEN*i+XLEN +: XLEN];
      if (fwd_we[2*i]) rd_lo = fwd_data[2*XLEN*i +: XLEN];
    end
  end
  // Architectural state, pending count and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rd_data  = {rd_hi, rd_lo};
  assign rd_stall = rd_req && !cnt_zero && !(cnt_q == PW'(1) && md_done && !flush);
  assign pend_cnt = cnt_q;
  assign pend_err = err_q;
endmodule

// File: tb/tb_hilo_bank.sv
// tb_hilo_bank: table-driven directed check of hilo_bank forwarding, pending tracking and errors
module tb_hilo_bank;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   fwd_we;
  logic [127:0] fwd_data;
  logic [1:0]   wb_we, md_we;
  logic [63:0]  wb_data, md_data, rd_data;
  logic         md_issue, md_done, flush, rd_req, rd_stall, pend_err;
  logic [1:0]   pend_cnt;
  int           n_tests = 0;
  int           n_fail = 0;
  typedef struct {
    logic [3:0]   fwd_we;
    logic [127:0] fwd_data;
    logic [1:0]   wb_we;
    logic [63:0]  wb_data;
    logic         iss, done;
    logic [1:0]   md_we;
    logic [63:0]  md_data;
    logic         flush, rd_req;
    logic [63:0]  e_rd;
    logic         e_stall;
    logic [1:0]   e_cnt;
    logic         e_err;
  } vec_t;
  vec_t tbl[$];
  hilo_bank dut (
    .clk(clk), .reset(reset), .fwd_we(fwd_we), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_data(wb_data), .md_issue(md_issue), .md_done(md_done),
    .md_we(md_we), .md_data(md_data), .flush(flush), .rd_req(rd_req),
    .rd_data(rd_data), .rd_stall(rd_stall), .pend_cnt(pend_cnt), .pend_err(pend_err)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [3:0] fw, logic [127:0] fd, logic [1:0] ww, logic [63:0] wd,
                              logic is, logic dn, logic [1:0] mw, logic [63:0] md, logic fl, logic rr,
                              logic [63:0] er, logic es, logic [1:0] ec, logic ee);
    vec_t v;
    v.fwd_we = fw; v.fwd_data = fd; v.wb_we = ww; v.wb_data = wd;
    v.iss = is; v.done = dn; v.md_we = mw; v.md_data = md; v.flush = fl; v.rd_req = rr;
    v.e_rd = er; v.e_stall = es; v.e_cnt = ec; v.e_err = ee;
    return v;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive_idle();
    fwd_we = '0; fwd_data = '0; wb_we = '0; wb_data = '0; md_issue = 0; md_done = 0;
    md_we = '0; md_data = '0; flush = 0; rd_req = 0;
  endtask
  task automatic run(string tag, vec_t v);
    fwd_we = v.fwd_we; fwd_data = v.fwd_data; wb_we = v.wb_we; wb_data = v.wb_data;
    md_issue = v.iss; md_done = v.done; md_we = v.md_we; md_data = v.md_data;
    flush = v.flush; rd_req = v.rd_req;
    #1;
    chk({tag, " rd_data"}, rd_data, v.e_rd);
    chk({tag, " rd_stall"}, {63'd0, rd_stall}, {63'd0, v.e_stall});
    chk({tag, " pend_cnt"}, {62'd0, pend_cnt}, {62'd0, v.e_cnt});
    chk({tag, " pend_err"}, {63'd0, pend_err}, {63'd0, v.e_err});
    @(negedge clk);
  endtask
  task automatic do_reset();
    drive_idle();
    md_issue = 1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    drive_idle();
  endtask
  initial begin
    reset = 1;
    drive_idle();
    // fw fd ww wd iss done mw md flush rd_req | e_rd e_stall e_cnt e_err
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b10, {32'hAAAA0000, 32'h1111}, 0, 0, 0, 0, 0, 1, {32'hAAAA0000, 32'h0}, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'hAAAA0000, 32'h0}, 0, 0, 0));
    tbl.push_back(mk(4'b1101, {32'h7, 32'h9, 32'h0, 32'h5}, 2'b10, {32'h3, 32'h0}, 0, 0, 0, 0, 0, 1, {32'h7, 32'h5}, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h3, 32'h0}, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {32'h3, 32'h0}, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h3, 32'h0}, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h3, 32'h0}, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2'b11, {32'h9, 32'h8}, 0, 1, {32'h9, 32'h8}, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h9, 32'h8}, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, {32'h9, 32'h8}, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {32'h9, 32'h8}, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, {32'h9, 32'h8}, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {32'h9, 32'h8}, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h9, 32'h8}, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2'b11, {32'hDEAD, 32'hBEEF}, 1, 1, {32'h9, 32'h8}, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h9, 32'h8}, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, {32'h9, 32'h8}, 0, 0, 1));
    tbl.push_back(mk(0, 0, 2'b11, {32'h33, 32'h44}, 0, 1, 2'b11, {32'h11, 32'h22}, 0, 1, {32'h33, 32'h44}, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h33, 32'h44}, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2'b11, {32'h55, 32'h66}, 0, 1, {32'h33, 32'h44}, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h33, 32'h44}, 0, 0, 1));
    repeat (2) @(negedge clk);
    reset = 0;
    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);
    // reset wins over a same-cycle issue; flushed issue/done raise no error
    do_reset();
    run("rst_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    run("flush_both", mk(0, 0, 0, 0, 1, 1, 2'b11, {32'h1, 32'h2}, 1, 1, 64'h0, 0, 0, 0));
    run("flush_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    // simultaneous issue and done at cnt=1 keeps the count; LO-only MDU write
    run("iss1", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0));
    run("iss_done", mk(0, 0, 0, 0, 1, 1, 2'b01, {32'hF, 32'hE}, 0, 1, {32'h0, 32'hE}, 0, 1, 0));
    run("hold_cnt", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h0, 32'hE}, 1, 1, 0));
    run("iss2", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, {32'h0, 32'hE}, 0, 1, 0));
    run("cnt2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {32'h0, 32'hE}, 1, 2, 0));
    // reset mid-operation drops pending ops; a later done is an error and writes nothing
    do_reset();
    run("rst_mid", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));
    run("late_done", mk(0, 0, 0, 0, 0, 1, 2'b11, {32'h1, 32'h2}, 0, 1, 64'h0, 0, 0, 0));
    run("err_set", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_bank.md
Name: hilo_bank

Overview:
- Parametrised successor to the single HI/LO register. Holds the architectural HI and LO halves, with separate per-half write enables.
- Forwards from a configurable number of in-flight pipeline stages to EX.
- Tracks outstanding multi-cycle multiply/divide operations and stalls EX reads of HI/LO until the result has landed.
- Sits beside the EX stage; writes come from WB and from the MDU completion port.

Parameters:
- XLEN, 32, width of each half (HI and LO); data buses are 2*XLEN, with HI in the upper half.
- NFWD, 2, number of forwarding stages; index 0 is the youngest (MEM).
- MAX_PEND, 3, maximum number of outstanding MDU operations.
- PW, 2, width of pend_cnt; must satisfy 2^PW > MAX_PEND.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fwd_we  in  2*NFWD  per-stage half enables; bits [2i+1:2i] belong to stage i; bit 1 = HI, bit 0 = LO.
- fwd_data  in  2*XLEN*NFWD  per-stage data; stage i occupies slice i.
- wb_we  in  2  WB half enables, {HI, LO}.
- wb_data  in  2*XLEN  WB data.
- md_issue  in  1  an MDU operation targeting HI/LO was issued this cycle.
- md_done  in  1  the MDU result is valid this cycle.
- md_we  in  2  MDU half enables, {HI, LO}.
- md_data  in  2*XLEN  MDU result.
- flush  in  1  pipeline flush; cancels all outstanding MDU operations.
- rd_req  in  1  EX is reading HI and/or LO this cycle.
- rd_data  out  2*XLEN  forwarded HI/LO value.
- rd_stall  out  1  EX must hold because the value is not yet available.
- pend_cnt  out  PW  number of outstanding MDU operations.
- pend_err  out  1  sticky protocol-error flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: HI=0, LO=0, pend_cnt=0, pend_err=0. Reset has priority over all inputs in the same cycle, and is valid mid-operation: outstanding operations are dropped and a later md_done is treated as an error.
- Register update at each posedge, applied per half:
  - md_done writes first, only when accepted.
  - wb_we then overrides. WB wins a same-cycle collision on the same half.
  - A half with no enable holds its value.
- md_done is accepted only when pend_cnt != 0 and flush = 0.
- rd_data is combinational and resolved per half independently. Priority, highest first:
  1. Forwarding stage 0 .. NFWD-1, first enabled stage wins.
  2. WB.
  3. Accepted md_done.
  4. The register.
- rd_data is driven regardless of rd_req.
- Pending counter:
  - next = cnt + issue_acc - done_acc.
  - issue_acc = md_issue and cnt != MAX_PEND and flush = 0.
  - done_acc as for md_done acceptance above.
  - Simultaneous accepted issue and done leaves cnt unchanged.
- Flush: cnt becomes 0 next cycle. A same-cycle md_issue or md_done is ignored and does not set pend_err. WB writes still commit (WB is architectural).
- Errors (pend_err set sticky; cleared only by reset):
  - md_issue at cnt == MAX_PEND: issue dropped, no count change.
  - md_done at cnt == 0 with flush = 0: no write, no count change.
- Stall: rd_stall = rd_req and cnt != 0 and not (cnt == 1 and md_done and flush = 0).
  - When cnt == 1 and md_done arrives, the result is bypassed through rd_data the same cycle with no stall.
  - When rd_req = 0, rd_stall = 0.
- A stalled read completes with zero extra latency once the last result lands: stall deasserts in the md_done cycle with cnt = 1.
- Zero-latency forwarding: a value written at posedge N is visible from the register at N+1. In cycle N itself it is visible via the WB or MDU bypass.

Test Plan:
- Reset, then rd_req=1 with no writes -> rd_data=0, rd_stall=0, pend_cnt=0, pend_err=0.
- wb_we=2'b10, wb_data={32'hAAAA0000, 32'h1111} -> same cycle, rd_data HI=AAAA0000 and LO=old 0 (bypass). Next cycle, register HI=AAAA0000 and LO=0.
- fwd_we stage0=2'b01 (LO=5), stage1=2'b11 (HI=7, LO=9), WB HI=3 -> rd_data HI=7 and LO=5, resolved per half by priority.
- md_issue with rd_req=1 held -> rd_stall=1 for the latency period, pend_cnt=1. Then md_done with md_data={9,8}, md_we=11 -> rd_stall=0 and rd_data={9,8} that cycle; pend_cnt=0 next cycle.
- Issue 3 operations, then a 4th md_issue -> pend_cnt stays 3 and pend_err=1. Then flush together with md_done -> pend_cnt=0 and no HI/LO change. pend_err stays 1 until reset.
- md_done and wb_we=11 on the same cycle with different data -> register holds the WB data. md_done with cnt=0 -> pend_err=1 and no write.
